// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbitration slice.
// State encodings, default data width and the grant-index width helper.
package uart_pkg;

    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    // Index width for n requesters, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector.
// Returns the first set request after ptr_i, wrapping modulo N.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between byte sources.
// Issues the TX start strobe, tracks busy, acks or times out each byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int DW           = DW_DEF,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                     clkIN,
    input  logic                     resetIN,
    input  logic [NREQ-1:0]          reqIN,
    input  logic [NREQ*DW-1:0]       dataIN,
    input  logic                     nBusyIN,
    output logic                     sendOUT,
    output logic [DW-1:0]            txDataOUT,
    output logic [NREQ-1:0]          ackOUT,
    output logic [idx_w(NREQ)-1:0]   grantOUT,
    output logic                     errOUT
);

    localparam int GW = idx_w(NREQ);
    localparam int CW = $clog2(BUSY_TIMEOUT);

    state_e          state_q;
    logic [GW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            send_q;
    logic [DW-1:0]   data_q;
    logic [GW-1:0]   grant_q;
    logic [NREQ-1:0] ack_q;
    logic            err_q;

    logic            pick_vld;
    logic [GW-1:0]   pick_idx;
    logic [DW-1:0]   pick_data;

    uart_rr_pick #(
        .N  (NREQ),
        .IW (GW)
    ) u_pick (
        .req_i   (reqIN),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    always_comb begin
        pick_data = dataIN[int'(pick_idx)*DW +: DW];
        cnt_d     = cnt_q + CW'(1);
    end

    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            state_q <= ST_IDLE;
            ptr_q   <= GW'(NREQ - 1);
            cnt_q   <= '0;
            send_q  <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (nBusyIN && pick_vld) begin
                        send_q  <= 1'b1;
                        data_q  <= pick_data;
                        grant_q <= pick_idx;
                        cnt_q   <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!nBusyIN) begin
                        send_q  <= 1'b0;
                        state_q <= ST_WAIT_DONE;
                    end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                        // TX never took the byte; give up, retry on next turn.
                        send_q  <= 1'b0;
                        err_q   <= 1'b1;
                        ptr_q   <= grant_q;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_WAIT_DONE: begin
                    send_q <= 1'b0;
                    if (nBusyIN) begin
                        ack_q   <= NREQ'(1) << grant_q;
                        ptr_q   <= grant_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    send_q  <= 1'b0;
                    data_q  <= '0;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign sendOUT   = send_q;
    assign txDataOUT = data_q;
    assign ackOUT    = ack_q;
    assign grantOUT  = grant_q;
    assign errOUT    = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small scripted TX-core model.
// Each task drives one scenario and checks against hand-computed values.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] data;
    logic        nbusy;
    logic        send;
    logic [7:0]  txd;
    logic [1:0]  ack;
    logic [0:0]  grant;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ         (2),
        .DW           (8),
        .BUSY_TIMEOUT (16)
    ) dut (
        .clkIN     (clk),
        .resetIN   (rst),
        .reqIN     (req),
        .dataIN    (data),
        .nBusyIN   (nbusy),
        .sendOUT   (send),
        .txDataOUT (txd),
        .ackOUT    (ack),
        .grantOUT  (grant),
        .errOUT    (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        req   = 2'b00;
        data  = 16'h0000;
        nbusy = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // TX model: drop busy drop_after cycles after sendOUT, hold busy_len
    // cycles, then release. drop_after==0 means the TX never responds.
    task automatic tx_xfer(
        input  int         drop_after,
        input  int         busy_len,
        output int         wait_cyc,
        output int         send_cyc,
        output logic [7:0] d,
        output logic [0:0] g,
        output logic [1:0] a,
        output logic [1:0] stray,
        output int         errs
    );
        wait_cyc = 0;
        send_cyc = 0;
        d        = '0;
        g        = '0;
        a        = '0;
        stray    = '0;
        errs     = 0;
        while (!send && wait_cyc < 20) begin
            step();
            wait_cyc++;
            errs  += int'(err);
            stray |= ack;
        end
        if (!send) return;
        g        = grant;
        d        = txd;
        send_cyc = 1;
        if (drop_after == 0) begin
            for (int i = 0; i < 40 && send; i++) begin
                step();
                errs  += int'(err);
                stray |= ack;
                if (send) begin
                    send_cyc++;
                    d = txd;
                end
            end
        end else begin
            for (int i = 1; i < drop_after; i++) begin
                step();
                errs  += int'(err);
                stray |= ack;
                if (send) begin
                    send_cyc++;
                    d = txd;
                end
            end
            nbusy = 1'b0;
            for (int i = 0; i < busy_len; i++) begin
                step();
                errs  += int'(err);
                stray |= ack;
                if (send) send_cyc++;
            end
            nbusy = 1'b1;
            step();
            a     = ack;
            errs += int'(err);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req   = 2'b11;
        data  = 16'hAA55;
        nbusy = 1'b1;
        step();
        step();
        total++;
        if (send !== 1'b0) begin
            bad++;
            $display("FAIL reset_send got=%0b want=0", send);
        end
        total++;
        if (txd !== 8'h00) begin
            bad++;
            $display("FAIL reset_txd got=%0h want=0", txd);
        end
        total++;
        if (ack !== 2'b00) begin
            bad++;
            $display("FAIL reset_ack got=%0b want=00", ack);
        end
        total++;
        if (grant !== 1'b0) begin
            bad++;
            $display("FAIL reset_grant got=%0d want=0", grant);
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got=%0b want=0", err);
        end
        rst = 1'b0;
        req = 2'b00;
        step();
    endtask

    task automatic test_single();
        int         w, sc, e;
        logic [7:0] d;
        logic [0:0] g;
        logic [1:0] a, s;
        apply_reset();
        req  = 2'b01;
        data = 16'h0041;
        tx_xfer(2, 10, w, sc, d, g, a, s, e);
        req = 2'b00;
        total++;
        if (w !== 1) begin
            bad++;
            $display("FAIL single_latency got=%0d want=1", w);
        end
        total++;
        if (sc !== 2) begin
            bad++;
            $display("FAIL single_send_len got=%0d want=2", sc);
        end
        total++;
        if (d !== 8'h41) begin
            bad++;
            $display("FAIL single_data got=%0h want=41", d);
        end
        total++;
        if (g !== 1'b0) begin
            bad++;
            $display("FAIL single_grant got=%0d want=0", g);
        end
        total++;
        if (a !== 2'b01 || s !== 2'b00 || e !== 0) begin
            bad++;
            $display("FAIL single_ack got=%0b stray=%0b err=%0d want=01/00/0",
                     a, s, e);
        end
        step();
        total++;
        if (send !== 1'b0 || ack !== 2'b00) begin
            bad++;
            $display("FAIL single_idle got send=%0b ack=%0b want 0/00",
                     send, ack);
        end
    endtask

    task automatic test_contention();
        int         w, sc, e;
        logic [7:0] d;
        logic [0:0] g;
        logic [1:0] a, s;
        logic [7:0] exp_d [4] = '{8'h55, 8'hAA, 8'h55, 8'hAA};
        logic [1:0] exp_a [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        apply_reset();
        req  = 2'b11;
        data = 16'hAA55;
        for (int k = 0; k < 4; k++) begin
            tx_xfer(2, 10, w, sc, d, g, a, s, e);
            if (k == 3) req = 2'b00;
            total++;
            if (d !== exp_d[k] || a !== exp_a[k]) begin
                bad++;
                $display("FAIL contend_%0d got data=%0h ack=%0b want %0h/%0b",
                         k, d, a, exp_d[k], exp_a[k]);
            end
            total++;
            if (w !== 1) begin
                bad++;
                $display("FAIL contend_gap_%0d got=%0d want=1", k, w);
            end
        end
        step();
    endtask

    task automatic test_busy_gating();
        int         w, sc, e;
        int         early;
        logic [7:0] d;
        logic [0:0] g;
        logic [1:0] a, s;
        apply_reset();
        nbusy = 1'b0;
        req   = 2'b01;
        data  = 16'h0033;
        early = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            early += int'(send);
        end
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL gate_hold got=%0d send cycles want=0", early);
        end
        nbusy = 1'b1;
        tx_xfer(2, 10, w, sc, d, g, a, s, e);
        req = 2'b00;
        total++;
        if (w !== 1) begin
            bad++;
            $display("FAIL gate_release got=%0d want=1", w);
        end
        total++;
        if (d !== 8'h33 || a !== 2'b01) begin
            bad++;
            $display("FAIL gate_xfer got data=%0h ack=%0b want 33/01", d, a);
        end
        step();
    endtask

    task automatic test_timeout();
        int         w, sc, e;
        logic [7:0] d;
        logic [0:0] g;
        logic [1:0] a, s;
        apply_reset();
        req  = 2'b11;
        data = 16'hAA55;
        tx_xfer(0, 0, w, sc, d, g, a, s, e);
        total++;
        if (sc !== 16) begin
            bad++;
            $display("FAIL tmo_send_len got=%0d want=16", sc);
        end
        total++;
        if (e !== 1) begin
            bad++;
            $display("FAIL tmo_err_pulses got=%0d want=1", e);
        end
        total++;
        if (s !== 2'b00 || g !== 1'b0) begin
            bad++;
            $display("FAIL tmo_noack got ack=%0b grant=%0d want 00/0", s, g);
        end
        tx_xfer(2, 10, w, sc, d, g, a, s, e);
        req = 2'b00;
        total++;
        if (g !== 1'b1 || d !== 8'hAA) begin
            bad++;
            $display("FAIL tmo_retry_grant got g=%0d d=%0h want 1/aa", g, d);
        end
        total++;
        if (a !== 2'b10 || e !== 0 || w !== 1) begin
            bad++;
            $display("FAIL tmo_retry_ack got a=%0b err=%0d gap=%0d want 10/0/1",
                     a, e, w);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int         w, sc, e;
        logic [7:0] d;
        logic [0:0] g;
        logic [1:0] a, s;
        apply_reset();
        req  = 2'b01;
        data = 16'h0041;
        step();
        nbusy = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        total++;
        if (send !== 1'b0 || txd !== 8'h00 || ack !== 2'b00 ||
            grant !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got s=%0b d=%0h a=%0b g=%0d e=%0b want 0s",
                     send, txd, ack, grant, err);
        end
        rst   = 1'b0;
        nbusy = 1'b1;
        req   = 2'b10;
        data  = 16'hAA41;
        tx_xfer(2, 10, w, sc, d, g, a, s, e);
        req = 2'b00;
        total++;
        if (g !== 1'b1 || d !== 8'hAA || w !== 1) begin
            bad++;
            $display("FAIL mid_regrant got g=%0d d=%0h gap=%0d want 1/aa/1",
                     g, d, w);
        end
        total++;
        if (s !== 2'b00 || a !== 2'b10) begin
            bad++;
            $display("FAIL mid_ack got stray=%0b ack=%0b want 00/10", s, a);
        end
        step();
    endtask

    task automatic test_withdraw();
        int         w, sc, e;
        int         regrant;
        logic [7:0] d;
        logic [0:0] g;
        logic [1:0] a, s;
        apply_reset();
        req  = 2'b01;
        data = 16'h0041;
        step();
        req  = 2'b00;
        data = 16'h00FF;
        tx_xfer(2, 10, w, sc, d, g, a, s, e);
        total++;
        if (sc !== 2 || d !== 8'h41) begin
            bad++;
            $display("FAIL wd_send got len=%0d data=%0h want 2/41", sc, d);
        end
        total++;
        if (a !== 2'b01) begin
            bad++;
            $display("FAIL wd_ack got=%0b want=01", a);
        end
        regrant = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            regrant += int'(send);
        end
        total++;
        if (regrant !== 0) begin
            bad++;
            $display("FAIL wd_regrant got=%0d want=0", regrant);
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = 2'b00;
        data  = 16'h0000;
        nbusy = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_busy_gating();
        test_timeout();
        test_reset_mid();
        test_withdraw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NREQ byte sources, e.g. the echo path and a status/banner generator.
- Selects a requester by round-robin and latches its byte.
- Drives the TX start strobe and follows the TX busy handshake (nBusyIN low = transmitting).
- Acknowledges the requester when its byte is fully sent.
- Sits between the byte producers and the UART TX core, in place of a single-source send strobe generator.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 8, data width per requester.
- BUSY_TIMEOUT, 16, cycles sendOUT may stay high without nBusyIN falling before the attempt is aborted (>=2).

Ports:
- clkIN  in  1  system clock, all logic on rising edge.
- resetIN  in  1  synchronous, active-high reset.
- reqIN  in  NREQ  per-requester level request; hold high with stable data until ackOUT.
- dataIN  in  NREQ*DW  packed bytes; requester i occupies bits [i*DW +: DW].
- nBusyIN  in  1  from TX core; 0 = transmitting, 1 = idle.
- sendOUT  out  1  start strobe to TX, registered.
- txDataOUT  out  DW  byte presented to TX, registered, stable from sendOUT rise until return to IDLE.
- ackOUT  out  NREQ  one-hot, one-cycle pulse: requester's byte completed.
- grantOUT  out  $clog2(NREQ) (min 1)  index of the current or last granted requester.
- errOUT  out  1  one-cycle pulse on busy-timeout abort.

Behaviour:
- Reset: state=IDLE; sendOUT=0; txDataOUT=0; ackOUT=0; grantOUT=0; errOUT=0; timeout counter=0; rr pointer=NREQ-1, so requester 0 has first priority. Reset mid-transfer aborts immediately; no ack is issued.
- States: IDLE, SEND, WAIT_DONE.
- IDLE, entry condition: nBusyIN=1 and any reqIN bit set.
  - Pick the first set bit searching from pointer+1 upward, wrapping modulo NREQ.
  - Latch txDataOUT and grantOUT; set sendOUT=1; clear the counter; go to SEND.
  - Latency: req sampled in cycle t gives sendOUT=1 in cycle t+1.
- IDLE with nBusyIN=0 (TX busy from elsewhere or still finishing): no grant.
- SEND: sendOUT held at 1.
  - nBusyIN=0: sendOUT<=0; go to WAIT_DONE.
  - Otherwise increment the counter.
  - Counter == BUSY_TIMEOUT-1 with nBusyIN still 1: sendOUT<=0; errOUT pulse; pointer<=granted index; no ack; go to IDLE. The requester is retried in its next round-robin turn.
- WAIT_DONE: sendOUT=0.
  - On nBusyIN=1: ackOUT[grant] pulses for 1 cycle; pointer<=grant; go to IDLE.
  - Next grant is possible in the cycle after the ack, so back-to-back bytes are one idle cycle apart.
- Requester drops reqIN after being granted: the transfer still completes and ackOUT still pulses.
- Changes on dataIN after grant are ignored.
- Ack cycle: the acked requester must drop reqIN in the cycle after ackOUT, or it is treated as a new request in its next turn.
- Round-robin fairness: with all requesters continuously requesting, grants cycle 0,1,...,NREQ-1,0.
- Unused/invalid: state encodings outside the three states return to IDLE with outputs cleared.
- ackOUT and errOUT are never high in the same cycle. At most one ackOUT bit is ever set.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants ST_IDLE=0, ST_SEND=1, ST_WAIT_DONE=2 (2-bit);
  - the default DW;
  - the width helper for grant index.
- One sub-module, uart_rr_pick: combinational round-robin selector.
  - Inputs: req vector and pointer.
  - Outputs: valid and index.
  - Reusable for other shared resources.

Test Plan:
- Single request: reset; reqIN=01, dataIN[7:0]=0x41, TX model drops nBusyIN 2 cycles after sendOUT and raises it 10 cycles later -> sendOUT high exactly 2 cycles, txDataOUT=0x41, ackOUT=01 one cycle after nBusyIN rises, grantOUT=0.
- Contention: reqIN=11, data 0x55/0xAA held across 4 transfers -> TX sees 0x55,0xAA,0x55,0xAA; ackOUT alternates 01,10.
- Busy gating: nBusyIN=0 when reqIN=01 asserted -> sendOUT stays 0 until nBusyIN=1, then rises on the next cycle.
- Timeout: TX model never drops nBusyIN, BUSY_TIMEOUT=16 -> sendOUT high 16 cycles, errOUT single pulse, no ack. Retry uses the next pointer: with reqIN=11 and the timeout on requester 0, requester 1 is granted next.
- Reset mid-operation: assert resetIN during WAIT_DONE -> next cycle all outputs 0. After release with reqIN=10, requester 1 is granted with no stale ack.
- Request withdrawn: drop reqIN during SEND -> transfer completes, ackOUT pulses, no re-grant.
